// File: rtl/ram_burst_pkg.sv
`default_nettype none
// ==========================================================================
// ram_burst_pkg : op codes, FSM encoding and default widths for the burst master
// Rev 1.0
// ==========================================================================
package ram_burst_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;

  typedef logic [1:0] op_t;

  localparam op_t OP_READ  = 2'b00;
  localparam op_t OP_WRITE = 2'b01;
  localparam op_t OP_CLEAR = 2'b10;
  localparam op_t OP_RSVD  = 2'b11;

  localparam int STATE_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/ram_burst_if.sv
`default_nettype none
// ==========================================================================
// ram_burst_if : command, write-beat, read-beat and RAM signals of the burst master
// Rev 1.0
// ==========================================================================
interface ram_burst_if
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;
  logic              ram_cs;
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_value;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, ram_value,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, err,
           ram_cs, ram_read, ram_write, ram_addr, ram_data_in
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, ram_value,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, err,
           ram_cs, ram_read, ram_write, ram_addr, ram_data_in
  );
endinterface
`default_nettype wire

// File: rtl/ram_rd_pipe.sv
`default_nettype none
// ==========================================================================
// ram_rd_pipe : 2-stage read-valid tracker and read-data capture register
// Rev 1.0
// ==========================================================================
module ram_rd_pipe
  import ram_burst_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              strobe,
  input  logic [DATA_W-1:0] ram_value,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);
  logic stage1;
  logic stage2;

  // stage1 marks the cycle the RAM presents data; stage2 marks the captured beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1  <= 1'b0;
      stage2  <= 1'b0;
      rd_data <= '0;
    end else if (clr) begin
      stage1  <= 1'b0;
      stage2  <= 1'b0;
    end else begin
      stage1 <= strobe;
      stage2 <= stage1;
      if (stage1) rd_data <= ram_value;
    end
  end

  assign busy     = stage1;
  assign rd_valid = stage2;

endmodule
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// ==========================================================================
// ram_burst_master : burst READ/WRITE/CLEAR engine for a registered-read RAM
// CLEAR op is enabled by defining RAM_BURST_CLEAR_EN.       Rev 1.0
// ==========================================================================
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_burst_if.master bus
);
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt_state;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  cnt;
  logic               err_q;
  logic               cmd_ready_q;
  logic               cmd_fire;
  logic               wr_fire;
  logic               last_beat;
  logic               pipe_busy;
  logic               pipe_valid;
  logic [DATA_W-1:0]  pipe_data;

  assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
  assign wr_fire   = (state == ST_WRITE) & bus.wr_valid;
  assign last_beat = (cnt == '0);

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OP_READ:  nxt_state = ST_READ;
            OP_WRITE: nxt_state = ST_WRITE;
`ifdef RAM_BURST_CLEAR_EN
            OP_CLEAR: nxt_state = ST_CLEAR;
`else
            OP_CLEAR: nxt_state = ST_DONE;
`endif
            OP_RSVD:  nxt_state = ST_DONE;
          endcase
        end
      end
      ST_READ:  if (last_beat) nxt_state = ST_DRAIN;
      ST_WRITE: if (wr_fire && last_beat) nxt_state = ST_DONE;
`ifdef RAM_BURST_CLEAR_EN
      ST_CLEAR: if (last_beat) nxt_state = ST_DONE;
`else
      ST_CLEAR: nxt_state = ST_DONE;
`endif
      // Leave only once the last strobe has travelled through the capture register
      ST_DRAIN: if (!bus.ram_read && !pipe_busy) nxt_state = ST_DONE;
      ST_DONE:  nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      addr            <= '0;
      cnt             <= '0;
      err_q           <= 1'b0;
      cmd_ready_q     <= 1'b0;
      bus.ram_cs      <= 1'b0;
      bus.ram_read    <= 1'b0;
      bus.ram_write   <= 1'b0;
      bus.ram_addr    <= '0;
      bus.ram_data_in <= '0;
    end else begin
      state         <= nxt_state;
      cmd_ready_q   <= (nxt_state == ST_IDLE);
      bus.ram_cs    <= 1'b0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            addr  <= bus.cmd_addr;
            cnt   <= bus.cmd_len;
            err_q <= (nxt_state == ST_DONE);
          end
        end
        ST_READ: begin
          bus.ram_cs   <= 1'b1;
          bus.ram_read <= 1'b1;
          bus.ram_addr <= addr;
          addr         <= addr + 1'b1;
          cnt          <= cnt - 1'b1;
        end
        ST_WRITE: begin
          if (wr_fire) begin
            bus.ram_cs      <= 1'b1;
            bus.ram_write   <= 1'b1;
            bus.ram_addr    <= addr;
            bus.ram_data_in <= bus.wr_data;
            addr            <= addr + 1'b1;
            cnt             <= cnt - 1'b1;
          end
        end
`ifdef RAM_BURST_CLEAR_EN
        ST_CLEAR: begin
          bus.ram_cs      <= 1'b1;
          bus.ram_write   <= 1'b1;
          bus.ram_addr    <= addr;
          bus.ram_data_in <= '0;
          addr            <= addr + 1'b1;
          cnt             <= cnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  ram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state == ST_IDLE),
    .strobe    (bus.ram_read),
    .ram_value (bus.ram_value),
    .busy      (pipe_busy),
    .rd_valid  (pipe_valid),
    .rd_data   (pipe_data)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = (state == ST_WRITE);
  assign bus.rd_valid  = pipe_valid;
  assign bus.rd_data   = pipe_data;
  assign bus.done      = (state == ST_DONE);
  assign bus.err       = (state == ST_DONE) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// ==========================================================================
// tb_ram_burst_master : directed table-driven bench with a registered-read RAM model
// Rev 1.0
// ==========================================================================
module tb_ram_burst_master;
  import ram_burst_pkg::*;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       addr;
    logic [3:0]       len;
    logic [4:0]       gap_at;
    logic [3:0][7:0]  wdata;
    logic             exp_err;
    logic [4:0]       beats;
    logic [4:0]       exp_gap;
    logic [3:0][3:0]  exp_addr;
    logic [3:0][7:0]  exp_data;
  } vec_t;

  logic       clk;
  logic       rst_n;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         viol = 0;
  logic [7:0] mem [16];
  vec_t       vecs [8];

  ram_burst_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_burst_master #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with one-cycle registered read
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data_in;
    if (bus.ram_read)  bus.ram_value <= mem[bus.ram_addr];
  end

  always @(negedge clk) begin
    if (rst_n && ((bus.ram_read && bus.ram_write) || (bus.ram_cs != (bus.ram_read | bus.ram_write))))
      viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'd0, bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.done, bus.err,
            bus.ram_cs, bus.ram_read, bus.ram_write, bus.ram_addr, bus.ram_data_in};
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a, input logic [3:0] l,
                              input logic [4:0] g, input logic [31:0] wd, input logic e,
                              input logic [4:0] b, input logic [4:0] gp,
                              input logic [15:0] ea, input logic [31:0] ed);
    vec_t v;
    v.op = op; v.addr = a; v.len = l; v.gap_at = g; v.wdata = wd; v.exp_err = e;
    v.beats = b; v.exp_gap = gp; v.exp_addr = ea; v.exp_data = ed;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] w_addr [16];
    logic [7:0] w_data [16];
    logic [3:0] r_addr [16];
    logic [7:0] rv_data [16];
    int nw = 0, nr = 0, nrv = 0, gap_cnt = 0, cs_cnt = 0, widx = 0, gap_left = 2;
    int first_rd = 0, first_rv = 0, last_rv = 0;
    logic done_seen = 1'b0, err_seen = 1'b0;

    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.ram_cs) cs_cnt++;
      if (bus.ram_write && nw < 16) begin
        w_addr[nw] = bus.ram_addr; w_data[nw] = bus.ram_data_in; nw++;
      end
      if (bus.ram_read && nr < 16) begin
        if (nr == 0) first_rd = cyc;
        r_addr[nr] = bus.ram_addr; nr++;
      end
      if (bus.rd_valid && nrv < 16) begin
        if (nrv == 0) first_rv = cyc;
        last_rv = cyc; rv_data[nrv] = bus.rd_data; nrv++;
      end
      if (nw > 0 && nw < int'(v.beats) && !bus.ram_cs) gap_cnt++;
      if (bus.done) begin
        done_seen = 1'b1; err_seen = bus.err;
      end
      if (bus.wr_ready && widx <= int'(v.len)) begin
        if (widx == int'(v.gap_at) && gap_left > 0) begin
          bus.wr_valid = 1'b0; gap_left--;
        end else begin
          bus.wr_valid = 1'b1; bus.wr_data = v.wdata[widx]; widx++;
        end
      end else begin
        bus.wr_valid = 1'b0;
      end
    end

    chk($sformatf("v%0d_done_seen", idx), 32'(done_seen), 32'd1);
    if (done_seen) chk($sformatf("v%0d_err", idx), 32'(err_seen), 32'(v.exp_err));
    chk($sformatf("v%0d_gap_cycles", idx), gap_cnt, 32'(v.exp_gap));
    if (v.exp_err) begin
      chk($sformatf("v%0d_cs_cycles", idx), cs_cnt, 32'd0);
    end else if (v.op == OP_READ) begin
      chk($sformatf("v%0d_strobes", idx), nr, 32'(v.beats));
      chk($sformatf("v%0d_rd_beats", idx), nrv, 32'(v.beats));
      for (int i = 0; i < int'(v.beats) && i < nr; i++)
        chk($sformatf("v%0d_rd_addr%0d", idx, i), 32'(r_addr[i]), 32'(v.exp_addr[i]));
      for (int i = 0; i < int'(v.beats) && i < nrv; i++)
        chk($sformatf("v%0d_rd_data%0d", idx, i), 32'(rv_data[i]), 32'(v.exp_data[i]));
      if (nrv > 0) begin
        chk($sformatf("v%0d_rd_latency", idx), first_rv - first_rd, 32'd2);
        chk($sformatf("v%0d_rd_span", idx), last_rv - first_rv, 32'(v.beats) - 32'd1);
      end
    end else begin
      chk($sformatf("v%0d_wr_beats", idx), nw, 32'(v.beats));
      for (int i = 0; i < int'(v.beats) && i < nw; i++) begin
        chk($sformatf("v%0d_wr_addr%0d", idx, i), 32'(w_addr[i]), 32'(v.exp_addr[i]));
        chk($sformatf("v%0d_wr_data%0d", idx, i), 32'(w_data[i]), 32'(v.exp_data[i]));
      end
    end
  endtask

  initial begin
    int nr;
    int rv_after;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 4'h0;
    bus.cmd_len   = 4'h0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;

    vecs[0] = mk(OP_WRITE, 4'h3, 4'h3, 5'h1F, 32'hD4C3B2A1, 1'b0, 5'd4, 5'd0, 16'h6543, 32'hD4C3B2A1);
    vecs[1] = mk(OP_READ,  4'h3, 4'h3, 5'h1F, 32'h0,        1'b0, 5'd4, 5'd0, 16'h6543, 32'hD4C3B2A1);
    vecs[2] = mk(OP_WRITE, 4'hE, 4'h2, 5'h1F, 32'h00332211, 1'b0, 5'd3, 5'd0, 16'h00FE, 32'h00332211);
    vecs[3] = mk(OP_READ,  4'hE, 4'h2, 5'h1F, 32'h0,        1'b0, 5'd3, 5'd0, 16'h00FE, 32'h00332211);
    vecs[4] = mk(OP_WRITE, 4'h8, 4'h2, 5'd1,  32'h00776655, 1'b0, 5'd3, 5'd2, 16'h0A98, 32'h00776655);
`ifdef RAM_BURST_CLEAR_EN
    vecs[5] = mk(OP_CLEAR, 4'h5, 4'h3, 5'h1F, 32'h0, 1'b0, 5'd4, 5'd0, 16'h8765, 32'h00000000);
    vecs[6] = mk(OP_READ,  4'h5, 4'h3, 5'h1F, 32'h0, 1'b0, 5'd4, 5'd0, 16'h8765, 32'h00000000);
`else
    vecs[5] = mk(OP_CLEAR, 4'h5, 4'h3, 5'h1F, 32'h0, 1'b1, 5'd0, 5'd0, 16'h0000, 32'h00000000);
    vecs[6] = mk(OP_READ,  4'h5, 4'h3, 5'h1F, 32'h0, 1'b0, 5'd4, 5'd0, 16'h8765, 32'h55FFD4C3);
`endif
    vecs[7] = mk(OP_RSVD,  4'h2, 4'h1, 5'h1F, 32'h0, 1'b1, 5'd0, 5'd0, 16'h0000, 32'h00000000);

    #12;
    chk("reset_outputs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(bus.cmd_ready), 32'd1);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Reset while the second read beat is on the RAM strobe
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_READ;
    bus.cmd_addr  = 4'h3;
    bus.cmd_len   = 4'h3;
    nr = 0;
    for (int c = 0; c < 20 && nr < 2; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.ram_read) nr++;
    end
    chk("rst_seq_strobes", nr, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", outs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv_after = 0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      if (bus.rd_valid) rv_after++;
      @(negedge clk);
    end
    chk("rst_mid_no_rd_valid", rv_after, 32'd0);
    chk("rst_mid_no_cs", 32'(bus.ram_cs), 32'd0);

    chk("rw_strobe_rules", viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL use one clock, `clk`, and an asynchronous active-low reset, `rst_n`.
REQ-004 The block SHALL have exactly these ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  2  00=READ, 01=WRITE, 10=CLEAR, 11=reserved
- cmd_addr  in  ADDR_W  burst base address
- cmd_len  in  ADDR_W  beat count minus one (1..16 beats)
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted when both high
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat present (no backpressure)
- rd_data  out  DATA_W  read beat data
- done  out  1  one-cycle burst completion pulse
- err  out  1  qualifies done: command rejected
- ram_cs  out  1  RAM chip select
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_data_in  out  DATA_W  RAM write data
- ram_value  in  DATA_W  RAM registered read data

Function
REQ-005 All ram_* outputs SHALL be registered; ram_cs SHALL equal ram_read|ram_write; ram_read and ram_write SHALL never be high together.
REQ-006 FSM states SHALL be IDLE, READ, WRITE, CLEAR, DRAIN, DONE; cmd_ready SHALL be high only in IDLE.
REQ-007 On a cmd handshake, the block SHALL latch addr/len, load beat counter = cmd_len, and enter READ, WRITE or CLEAR by cmd_op; cmd_op 11 SHALL go to DONE with err=1.
REQ-008 READ: one read strobe per cycle, addr incrementing modulo 2^ADDR_W (0xF wraps to 0x0); after the (len+1)th strobe, go to DRAIN.
REQ-009 rd_valid SHALL assert exactly two cycles after the cycle a read strobe is registered in the block (ram_read high); rd_data SHALL be ram_value, i.e. latency = strobe + 1 RAM cycle + 1 capture register.
REQ-010 DRAIN SHALL wait until the last rd_valid has been issued, then go to DONE.
REQ-011 WRITE: wr_ready SHALL be high only in WRITE; each wr handshake SHALL register ram_write=1, ram_addr and ram_data_in=wr_data next cycle; wr_valid low SHALL insert idle cycles (ram_cs=0); after the last beat, go to DONE.
REQ-012 DONE SHALL last one cycle with done=1 (err as decided), then return to IDLE; back-to-back commands SHALL be accepted the following cycle.
REQ-013 Beats per burst SHALL be exactly cmd_len+1; bursts SHALL not abort early.

Reset
REQ-014 On rst_n low, the block SHALL go to IDLE; all outputs SHALL be 0, except cmd_ready=0 during reset and 1 the first cycle after release.
REQ-015 Reset mid-burst SHALL discard in-flight read data: no rd_valid after release for pre-reset strobes.

Configuration
REQ-016 With RAM_BURST_CLEAR_EN defined, CLEAR SHALL write 0x00 to len+1 consecutive addresses, one per cycle, without wr handshakes, then go to DONE with err=0.
REQ-017 Without RAM_BURST_CLEAR_EN, cmd_op 10 SHALL be treated as reserved (DONE, err=1, no RAM access).

Structure
REQ-018 Op codes, state encoding and default widths SHALL live in a shared package ram_burst_pkg.
REQ-019 The read-latency tracking SHALL be a sub-module ram_rd_pipe (2-stage valid shift register with clear).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- WRITE addr 0x3 len 3, data A1,B2,C3,D4 -> ram_write at 3..6 with that data; done, err=0.
- READ addr 0x3 len 3 after the write -> rd_valid 4 consecutive cycles with A1,B2,C3,D4; first one 2 cycles after first ram_read.
- WRITE addr 0xE len 2 -> addresses E,F,0.
- wr_valid gap of 2 cycles mid-burst -> 2 cycles with ram_cs=0; beat count still 3.
- cmd_op 10: with macro -> addresses 5..8 read back 00; without macro -> done+err, ram_cs never high.
- rst_n low during READ beat 2 -> outputs 0 immediately; no rd_valid after release; cmd_ready=1.
